// File: rtl/sz_code_packer_if.sv
// Handshake bundle between the curve-fit stage, the code packer and the output writer.
// slave is the packer side; master is the upstream producer plus the downstream consumers.
interface sz_code_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_code;
  logic [31:0] in_data;
  logic        flush;
  logic [31:0] code_word;
  logic [4:0]  code_count;
  logic        code_valid;
  logic        code_ready;
  logic [31:0] unpred_data;
  logic        unpred_valid;
  logic        unpred_ready;
  logic        done;

  modport slave (
    input  in_valid, in_code, in_data, flush, code_ready, unpred_ready,
    output in_ready, code_word, code_count, code_valid, unpred_data, unpred_valid, done
  );

  modport master (
    output in_valid, in_code, in_data, flush, code_ready, unpred_ready,
    input  in_ready, code_word, code_count, code_valid, unpred_data, unpred_valid, done
  );
endinterface

// File: rtl/sz_code_packer.sv
// Packs 2-bit fit codes into 32-bit words and diverts unpredictable raw floats to an
// escape FIFO; a flush emits any partial word, drains both streams and pulses done.
module sz_code_packer #(
  parameter int unsigned CODES_PER_WORD = 16,
  parameter int unsigned UNPRED_DEPTH   = 8
) (
  input logic               i_clk,
  input logic               i_rst_n,
  sz_code_packer_if.slave   io_bus
);

  localparam int unsigned AW   = $clog2(UNPRED_DEPTH);
  localparam int unsigned CW   = $clog2(CODES_PER_WORD);
  localparam int unsigned AccW = 2 * (CODES_PER_WORD - 1);

  typedef enum logic [1:0] {StRun, StFlush, StDrain, StDone} state_e;

  state_e            r_state;
  logic [AccW-1:0]   r_acc;
  logic [CW-1:0]     r_acc_cnt;
  logic [31:0]       r_word;
  logic [4:0]        r_count;
  logic              r_cvalid;
  logic              r_done;
  logic [31:0]       r_mem [UNPRED_DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_fcnt;

  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_last;
  logic w_out_free;
  logic w_in_ready;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_drain;

  assign w_fifo_full  = (r_fcnt == (AW + 1)'(UNPRED_DEPTH));
  assign w_fifo_empty = (r_fcnt == '0);
  assign w_last       = (r_acc_cnt == CW'(CODES_PER_WORD - 1));
  assign w_drain      = r_cvalid & io_bus.code_ready;
  assign w_out_free   = !r_cvalid | io_bus.code_ready;
  // Gated by reset so the producer sees not-ready while the block is held in reset.
  assign w_in_ready   = i_rst_n & (r_state == StRun) & !io_bus.flush & !w_fifo_full &
                        (!w_last | w_out_free);
  assign w_accept     = io_bus.in_valid & w_in_ready;
  assign w_push       = w_accept & (io_bus.in_code == 2'b00);
  assign w_pop        = !w_fifo_empty & io_bus.unpred_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StRun;
      r_acc     <= '0;
      r_acc_cnt <= '0;
      r_word    <= '0;
      r_count   <= '0;
      r_cvalid  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_drain) r_cvalid <= 1'b0;
      unique case (r_state)
        StRun: begin
          if (w_accept) begin
            if (w_last) begin
              r_word    <= {io_bus.in_code, r_acc};
              r_count   <= 5'(CODES_PER_WORD);
              r_cvalid  <= 1'b1;
              r_acc     <= '0;
              r_acc_cnt <= '0;
            end else begin
              r_acc[{r_acc_cnt, 1'b0} +: 2] <= io_bus.in_code;
              r_acc_cnt                     <= r_acc_cnt + 1'b1;
            end
          end
          if (io_bus.flush) r_state <= StFlush;
        end
        StFlush: begin
          if (r_acc_cnt == '0) begin
            r_state <= StDrain;
          end else if (w_out_free) begin
            // Unused slots are already zero: the accumulator is cleared on every load.
            r_word    <= {2'b00, r_acc};
            r_count   <= {1'b0, r_acc_cnt};
            r_cvalid  <= 1'b1;
            r_acc     <= '0;
            r_acc_cnt <= '0;
            r_state   <= StDrain;
          end
        end
        StDrain: begin
          if (!r_cvalid && w_fifo_empty) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end
        end
        StDone:  r_state <= StRun;
        default: r_state <= StRun;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_fcnt <= r_fcnt + 1'b1;
      else if (!w_push && w_pop) r_fcnt <= r_fcnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= io_bus.in_data;
  end

  assign io_bus.in_ready     = w_in_ready;
  assign io_bus.code_word    = r_word;
  assign io_bus.code_count   = r_count;
  assign io_bus.code_valid   = r_cvalid;
  assign io_bus.unpred_valid = !w_fifo_empty;
  assign io_bus.unpred_data  = w_fifo_empty ? 32'h0 : r_mem[r_rptr];
  assign io_bus.done         = r_done;

endmodule

// File: tb/tb_sz_code_packer.sv
// Randomised and directed bench for sz_code_packer against a queue-based model of the
// code grouping and escape ordering; inputs change on the falling edge.
module tb_sz_code_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sz_code_packer_if ifc ();

  sz_code_packer #(.CODES_PER_WORD(16), .UNPRED_DEPTH(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (ifc)
  );

  int total = 0;
  int bad = 0;
  int n_acc = 0;
  int n_done = 0;
  int n_cv = 0;
  int n_stall = 0;

  logic [1:0]  acc_q[$];
  logic [36:0] exp_words[$];
  logic [36:0] got_words[$];
  logic [31:0] exp_esc[$];
  logic [31:0] got_esc[$];

  logic        p_hold_c = 1'b0;
  logic        p_hold_u = 1'b0;
  logic [36:0] p_word;
  logic [31:0] p_esc;

  // Expected {count, word}: code i occupies bits [2i+1:2i], unused bits zero.
  function automatic logic [36:0] pack_codes(input logic [1:0] q[$]);
    logic [31:0] w = '0;
    foreach (q[i]) w = w | (32'(q[i]) << (2 * i));
    return {5'(q.size()), w};
  endfunction

  // Observer sampling 1 time unit before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (rst_n) begin
      if (p_hold_c) begin
        total++;
        if ({ifc.code_valid, ifc.code_count, ifc.code_word} !== {1'b1, p_word}) begin
          bad++;
          $display("FAIL code_hold: got %h want %h", {ifc.code_count, ifc.code_word}, p_word);
        end
      end
      if (p_hold_u) begin
        total++;
        if ({ifc.unpred_valid, ifc.unpred_data} !== {1'b1, p_esc}) begin
          bad++;
          $display("FAIL esc_hold: got %h want %h", ifc.unpred_data, p_esc);
        end
      end
      if (ifc.in_valid && !ifc.in_ready) n_stall++;
      if (ifc.in_valid && ifc.in_ready) begin
        n_acc++;
        if (ifc.in_code == 2'b00) exp_esc.push_back(ifc.in_data);
        acc_q.push_back(ifc.in_code);
        if (acc_q.size() == 16) begin
          exp_words.push_back(pack_codes(acc_q));
          acc_q.delete();
        end
      end
      if (ifc.code_valid) n_cv++;
      if (ifc.code_valid && ifc.code_ready) got_words.push_back({ifc.code_count, ifc.code_word});
      if (ifc.unpred_valid && ifc.unpred_ready) got_esc.push_back(ifc.unpred_data);
      if (ifc.done) n_done++;
      p_hold_c = ifc.code_valid && !ifc.code_ready;
      p_word   = {ifc.code_count, ifc.code_word};
      p_hold_u = ifc.unpred_valid && !ifc.unpred_ready;
      p_esc    = ifc.unpred_data;
    end else begin
      p_hold_c = 1'b0;
      p_hold_u = 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [1:0] c, input logic [31:0] d);
    int n = 0;
    ifc.in_valid = 1'b1;
    ifc.in_code  = c;
    ifc.in_data  = d;
    #4;
    while (!ifc.in_ready && n < 500) begin
      @(negedge clk);
      #4;
      n++;
    end
    if (n >= 500) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1 within 500 cycles");
    end
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask

  task automatic do_flush(output int cyc_n);
    int d0 = n_done;
    cyc_n = 0;
    if (acc_q.size() != 0) begin
      exp_words.push_back(pack_codes(acc_q));
      acc_q.delete();
    end
    ifc.flush = 1'b1;
    @(negedge clk);
    ifc.flush = 1'b0;
    while (n_done == d0 && cyc_n < 500) begin
      @(negedge clk);
      cyc_n++;
    end
    if (n_done == d0) begin
      total++;
      bad++;
      $display("FAIL flush_timeout: got no done want done within 500 cycles");
    end
  endtask

  task automatic clear_streams();
    exp_words.delete();
    got_words.delete();
    exp_esc.delete();
    got_esc.delete();
  endtask

  task automatic test_reset();
    ifc.in_valid = 1'b0; ifc.in_code = 2'b00; ifc.in_data = '0; ifc.flush = 1'b0;
    ifc.code_ready = 1'b0; ifc.unpred_ready = 1'b0;
    rst_n = 1'b0;
    cyc(2);
    total++;
    if (ifc.in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_in_ready: got %b want 0", ifc.in_ready);
    end
    total++;
    if ({ifc.code_valid, ifc.unpred_valid, ifc.done, ifc.code_count, ifc.code_word,
         ifc.unpred_data} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h/%h/%b want all zero", ifc.code_word,
                      ifc.unpred_data, {ifc.code_valid, ifc.unpred_valid, ifc.done});
    end
    rst_n = 1'b1;
    cyc(1);
    total++;
    if (ifc.in_ready !== 1'b1) begin
      bad++; $display("FAIL release_in_ready: got %b want 1", ifc.in_ready);
    end
  endtask

  task automatic test_full_word();
    int s0 = n_stall;
    int c0 = n_cv;
    int fl;
    ifc.code_ready = 1'b1; ifc.unpred_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(2'b01, $urandom());
    cyc(3);
    total++;
    if (n_stall != s0) begin bad++; $display("FAIL full_stall: got %0d want 0", n_stall - s0); end
    total++;
    if (n_cv - c0 != 1) begin bad++; $display("FAIL full_valid_len: got %0d want 1", n_cv - c0); end
    do_flush(fl);
    total++;
    if (fl != 3) begin bad++; $display("FAIL empty_flush_lat: got %0d want 3", fl); end
    total++;
    if (got_words.size() != 1 || got_words[0] !== {5'd16, 32'h55555555}) begin
      bad++; $display("FAIL full_word: got n=%0d %h want 1 %h", got_words.size(),
                      got_words.size() ? got_words[0] : 37'h0, {5'd16, 32'h55555555});
    end
    clear_streams();
  endtask

  task automatic test_stall();
    int a0 = n_acc;
    int n = 0;
    int fl;
    ifc.code_ready = 1'b0;
    ifc.in_valid = 1'b1; ifc.in_code = 2'b10; ifc.in_data = '0;
    cyc(40);
    total++;
    if (n_acc - a0 != 31) begin bad++; $display("FAIL stall_accepts: got %0d want 31", n_acc - a0); end
    total++;
    if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready: got %b want 0", ifc.in_ready); end
    total++;
    if ({ifc.code_valid, ifc.code_count, ifc.code_word} !== {1'b1, 5'd16, 32'hAAAAAAAA}) begin
      bad++; $display("FAIL stall_word: got %h want %h", ifc.code_word, 32'hAAAAAAAA);
    end
    ifc.code_ready = 1'b1;
    while (n_acc - a0 < 40 && n < 200) begin @(negedge clk); n++; end
    ifc.in_valid = 1'b0;
    do_flush(fl);
    cyc(2);
    total++;
    if (got_words.size() != 3 || exp_words.size() != 3) begin
      bad++; $display("FAIL stall_words_n: got %0d want 3", got_words.size());
    end else begin
      foreach (exp_words[i]) begin
        total++;
        if (got_words[i] !== exp_words[i]) begin
          bad++; $display("FAIL stall_word_%0d: got %h want %h", i, got_words[i], exp_words[i]);
        end
      end
    end
    clear_streams();
  endtask

  task automatic test_escape();
    int d0 = n_done;
    int fl;
    ifc.code_ready = 1'b1; ifc.unpred_ready = 1'b1;
    send(2'b01, $urandom());
    send(2'b00, 32'h3fa66666);
    send(2'b10, $urandom());
    send(2'b00, 32'h3e6ee632);
    do_flush(fl);
    cyc(3);
    total++;
    if (got_esc.size() != 2 || got_esc[0] !== 32'h3fa66666 || got_esc[1] !== 32'h3e6ee632) begin
      bad++; $display("FAIL esc_order: got n=%0d want 3fa66666,3e6ee632", got_esc.size());
    end
    total++;
    if (got_words.size() != 1 || got_words[0] !== {5'd4, 32'h00000021}) begin
      bad++; $display("FAIL esc_word: got n=%0d want %h", got_words.size(), {5'd4, 32'h21});
    end
    total++;
    if (n_done - d0 != 1) begin bad++; $display("FAIL esc_done: got %0d want 1", n_done - d0); end
    clear_streams();
  endtask

  task automatic test_fifo_wrap();
    logic [31:0] vals[9];
    int a0;
    int fl;
    foreach (vals[i]) vals[i] = $urandom();
    ifc.code_ready = 1'b1; ifc.unpred_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(2'b00, vals[i]);
    a0 = n_acc;
    ifc.in_valid = 1'b1; ifc.in_code = 2'b00; ifc.in_data = vals[8];
    cyc(3);
    total++;
    if (n_acc != a0 || ifc.in_ready !== 1'b0) begin
      bad++; $display("FAIL fifo_full: got acc=%0d ready=%b want 0/0", n_acc - a0, ifc.in_ready);
    end
    ifc.unpred_ready = 1'b1;
    cyc(1);
    ifc.unpred_ready = 1'b0;
    total++;
    if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL fifo_reopen: got %b want 1", ifc.in_ready); end
    cyc(1);
    ifc.in_valid = 1'b0;
    total++;
    if (n_acc - a0 != 1) begin bad++; $display("FAIL fifo_ninth: got %0d want 1", n_acc - a0); end
    ifc.unpred_ready = 1'b1;
    cyc(12);
    total++;
    if (got_esc.size() != 9) begin
      bad++; $display("FAIL fifo_count: got %0d want 9", got_esc.size());
    end else begin
      foreach (vals[i]) begin
        total++;
        if (got_esc[i] !== vals[i]) begin
          bad++; $display("FAIL fifo_order_%0d: got %h want %h", i, got_esc[i], vals[i]);
        end
      end
    end
    do_flush(fl);
    clear_streams();
  endtask

  task automatic test_flush_stall();
    int d0;
    int n = 0;
    ifc.code_ready = 1'b1; ifc.unpred_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(2'b11, $urandom());
    ifc.code_ready = 1'b0;
    d0 = n_done;
    exp_words.push_back(pack_codes(acc_q));
    acc_q.delete();
    ifc.flush = 1'b1;
    cyc(1);
    ifc.flush = 1'b0;
    cyc(4);
    total++;
    if (n_done != d0) begin bad++; $display("FAIL early_done: got %0d want 0", n_done - d0); end
    total++;
    if ({ifc.code_valid, ifc.code_count, ifc.code_word} !== {1'b1, 5'd5, 32'h000003FF}) begin
      bad++; $display("FAIL partial_word: got %h/%0d want 000003ff/5", ifc.code_word, ifc.code_count);
    end
    ifc.code_ready = 1'b1;
    while (n_done == d0 && n < 100) begin @(negedge clk); n++; end
    cyc(3);
    total++;
    if (n_done - d0 != 1) begin bad++; $display("FAIL stall_done: got %0d want 1", n_done - d0); end
    total++;
    if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL post_done_ready: got %b want 1", ifc.in_ready); end
    total++;
    if (got_words.size() != 1 || got_words[0] !== exp_words[0]) begin
      bad++; $display("FAIL partial_taken: got n=%0d want %h", got_words.size(), exp_words[0]);
    end
    clear_streams();
  endtask

  task automatic test_mid_reset();
    ifc.code_ready = 1'b1; ifc.unpred_ready = 1'b1;
    for (int i = 0; i < 7; i++) send(2'b01, $urandom());
    rst_n = 1'b0;
    #1;
    total++;
    if ({ifc.in_ready, ifc.code_valid, ifc.unpred_valid, ifc.done, ifc.code_count,
         ifc.code_word, ifc.unpred_data} !== '0) begin
      bad++; $display("FAIL mid_reset: got %h/%b want all zero", ifc.code_word,
                      {ifc.in_ready, ifc.code_valid, ifc.unpred_valid, ifc.done});
    end
    acc_q.delete();
    clear_streams();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    for (int i = 0; i < 16; i++) send(2'b11, $urandom());
    cyc(3);
    total++;
    if (got_words.size() != 1 || got_words[0] !== {5'd16, 32'hFFFFFFFF}) begin
      bad++; $display("FAIL post_reset_word: got n=%0d %h want %h", got_words.size(),
                      got_words.size() ? got_words[0] : 37'h0, {5'd16, 32'hFFFFFFFF});
    end
    clear_streams();
  endtask

  task automatic test_random();
    for (int b = 0; b < 3; b++) begin
      int len = $urandom_range(20, 80);
      int a0 = n_acc;
      int n = 0;
      int fl;
      while (n_acc - a0 < len && n < 2000) begin
        ifc.in_valid     = ($urandom_range(0, 3) != 0);
        ifc.in_code      = 2'($urandom_range(0, 3));
        ifc.in_data      = $urandom();
        ifc.code_ready   = ($urandom_range(0, 2) != 0);
        ifc.unpred_ready = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        n++;
      end
      ifc.in_valid = 1'b0; ifc.code_ready = 1'b1; ifc.unpred_ready = 1'b1;
      do_flush(fl);
      cyc(2);
      total++;
      if (got_words.size() != exp_words.size() || got_esc.size() != exp_esc.size()) begin
        bad++; $display("FAIL rand_sizes_%0d: got %0d/%0d want %0d/%0d", b, got_words.size(),
                        got_esc.size(), exp_words.size(), exp_esc.size());
      end else begin
        foreach (exp_words[i]) begin
          total++;
          if (got_words[i] !== exp_words[i]) begin
            bad++; $display("FAIL rand_word_%0d_%0d: got %h want %h", b, i, got_words[i], exp_words[i]);
          end
        end
        foreach (exp_esc[i]) begin
          total++;
          if (got_esc[i] !== exp_esc[i]) begin
            bad++; $display("FAIL rand_esc_%0d_%0d: got %h want %h", b, i, got_esc[i], exp_esc[i]);
          end
        end
      end
      clear_streams();
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_stall();
    test_escape();
    test_fifo_wrap();
    test_flush_stall();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sz_code_packer.md
# sz_code_packer

Packs the 2-bit per-point predictor codes from the 1-D curve-fit stage into 32-bit code words. In parallel, it diverts the raw float of every unpredictable point into a separate escape stream. It sits directly downstream of the fit stage and feeds the compressed-output writer. Both output streams use valid/ready handshakes, and a flush sequence closes a block cleanly.

## Interface
- CODES_PER_WORD, 16: codes packed per output word. Fixed at 32/2.
- UNPRED_DEPTH, 8: entries in the escape-value FIFO. Power of two, ≥2.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  code/data beat present
- in_code  in  2  fit code: 2'b00 = unpredictable; 01/10/11 = predictor index
- in_data  in  32  IEEE-754 single of the point (used only when in_code==00)
- in_ready  out  1  beat accepted on the edge where in_valid&in_ready
- flush  in  1  end-of-block request (level, sampled in RUN)
- code_word  out  32  packed codes; code i at bits [2i+1:2i], LSB first
- code_count  out  5  valid codes in code_word (16 for full words, 1–15 for a flushed partial word)
- code_valid  out  1  code_word/code_count valid
- code_ready  in  1  consumer accepts code word
- unpred_data  out  32  escape value, FIFO head
- unpred_valid  out  1  FIFO non-empty
- unpred_ready  in  1  consumer pops FIFO
- done  out  1  one-cycle pulse: block fully drained after flush

## Operation
- Datapath:
  - 30-bit accumulator plus a 4-bit count acc_cnt (0–15).
  - One-entry output register holding code_word, code_count and code_valid.
  - UNPRED_DEPTH FIFO, show-ahead, with registered write.
- Accept condition: in_ready = (state==RUN) & !flush & !fifo_full & (acc_cnt<15 | !code_valid | code_ready).
  - fifo_full blocks all beats, regardless of code.
- On an accepted beat:
  - The code is written at slot acc_cnt.
  - If in_code==00, in_data is pushed to the FIFO.
  - If acc_cnt==15, the 15 stored codes plus the new code load the output register with code_count=16 and acc_cnt returns to 0. Otherwise acc_cnt increments.
- Output register:
  - Cleared on the handshake (code_valid&code_ready) unless it is reloaded on the same edge.
  - A simultaneous drain and load is legal.
- FIFO:
  - A push and a pop in the same cycle are both performed.
  - Pointers wrap modulo UNPRED_DEPTH.
  - Occupancy is tracked with a depth+1 counter.
- State machine:
  - RUN: normal. When flush=1 → FLUSH.
  - FLUSH:
    - If acc_cnt==0 → DRAIN.
    - Otherwise, wait until the output register is free (or draining this edge). Then load the partial word: unused high bits 0, code_count=acc_cnt. Clear acc_cnt → DRAIN.
  - DRAIN: wait until code_valid==0 and the FIFO is empty → DONE.
  - DONE: done=1 for exactly one cycle → RUN (accumulator empty, fresh block).
- A beat presented in the same cycle flush is first high is NOT accepted; in_ready is already 0.
- Escape values leave in arrival order. The code stream carries no pointer to them.

## Timing
- Reset (rst=0, async) values:
  - in_ready=0 while rst is asserted, then 1 in the first cycle after release (RUN, empty).
  - code_word=0, code_count=0, code_valid=0.
  - unpred_data=0, unpred_valid=0, done=0, acc_cnt=0.
  - FIFO contents and any partial word are discarded.
- Code latency: the 16th code accepted on edge k → code_valid=1 after edge k. Held stable until code_ready is sampled high.
- Escape latency: a 00 beat accepted on edge k → unpred_valid=1 after edge k (if the FIFO was empty). unpred_data is stable while unpred_valid&!unpred_ready.
- Steady-state throughput: 1 beat/cycle when code_ready=1 and unpred_ready=1.
- Stalled code_ready: the block accepts 16+15=31 beats from empty, then in_ready=0.
- Flush → done: minimum 3 cycles (FLUSH, DRAIN, DONE) with empty buffers and ready consumers.

## Test plan
- Reset, then 16 beats of code 01 back-to-back with code_ready=1 → one word 32'h55555555, code_count=16, code_valid exactly 1 cycle; in_ready stays 1.
- code_ready=0 and 40 beats of code 10 offered continuously → exactly 31 accepted, then in_ready=0. code_word holds 32'hAAAAAAAA stable. Releasing code_ready resumes, with no code lost or duplicated.
- Beats (01,-), (00,32'h3fa66666), (10,-), (00,32'h3e6ee632), then flush →
  - unpred stream: 3fa66666 then 3e6ee632.
  - code_word=32'h00000021, code_count=4.
  - done pulses once after both streams drain.
- unpred_ready=0 and 9 beats of code 00 → 8 accepted, in_ready=0. Pop one → the 9th is accepted the next cycle. Order is preserved across the pointer wrap.
- 5 beats of code 11, then flush with code_ready=0 for 4 cycles → no done until the word 32'h000003FF / code_count=5 is taken. done is 1 cycle; in_ready returns to 1.
- 7 beats of code 01, then rst=0 mid-stream → all outputs are zero immediately. After release, 16 beats of code 11 → 32'hFFFFFFFF with no leftover 01 codes.
